// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register peripheral.
// Latency: none (declarations only).
// Backpressure: not applicable.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // First bit of every frame selects the access direction.
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // Frame length in bits: R/W bit, address field, data field.
  function automatic int frame_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_periph_if.sv
// Pin-side and register-side signal bundle of the SPI register peripheral.
// Latency: none (wiring only).
// Backpressure: none; the controller owns sclk/ncs/copi timing.
interface spi_regfile_periph_if #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8
);
  logic                       sclk;
  logic                       ncs;
  logic                       copi;
  logic                       cipo;
  logic                       cipo_oe;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic [NUM_REGS-1:0]        wr_pulse;
  logic                       frame_err;

  modport master (
    output sclk, ncs, copi,
    input  cipo, cipo_oe, regs_out, wr_pulse, frame_err
  );

  modport slave (
    input  sclk, ncs, copi,
    output cipo, cipo_oe, regs_out, wr_pulse, frame_err
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin with rise/fall pulses on the synchronised value.
// Latency: o_q follows the pin after SYNC_STAGES clk; edge pulses are valid in that same cycle.
// Backpressure: none; pulses last exactly one clk.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Move the pin through the synchroniser chain and keep the previous synchronised value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 target writing a register bank; optional CIPO readback when SPI_READBACK_EN is defined.
// Latency: regs_out/wr_pulse update SYNC_STAGES+2 clk after pin ncs rise; CIPO moves SYNC_STAGES+1 clk after pin sclk fall.
// Backpressure: none; controller must hold sclk high and low for at least SYNC_STAGES+2 clk each.
module spi_regfile_periph
  import spi_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  spi_regfile_periph_if.slave bus
);

  localparam int FRAME_W = frame_width(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  logic w_sclk_rise, w_sclk_fall;
  logic w_ncs_s, w_ncs_rise, w_ncs_fall;
  logic w_copi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_d(bus.sclk), .o_q(), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst(rst), .i_d(bus.ncs), .o_q(w_ncs_s), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst(rst), .i_d(bus.copi), .o_q(w_copi_s), .o_rise(), .o_fall()
  );

  state_t               r_state, w_state_nxt;
  logic                 r_armed;
  logic                 r_fall_pend;
  logic [CNT_W-1:0]     r_cnt;
  logic [FRAME_W-1:0]   r_sr;
  logic [FRAME_W-1:0]   w_sr_nxt;
  logic [DATA_W-1:0]    r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]  r_wr_pulse;
  logic                 r_frame_err;
  logic                 w_rw;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_data;

  // A sampled sclk edge with ncs low in SHIFT is a counted bit; ncs rising wins over a coincident sclk edge.
  wire w_bit_rise = (r_state == ST_SHIFT) && w_sclk_rise && !w_ncs_s;

  assign w_sr_nxt = {r_sr[FRAME_W-2:0], w_copi_s};
  assign w_rw     = r_sr[FRAME_W-1];
  assign w_addr   = r_sr[DATA_W +: ADDR_W];
  assign w_data   = r_sr[DATA_W-1:0];

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: frame opens on an armed ncs fall (possibly held over from DONE), closes on ncs rise.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (r_armed && (w_ncs_fall || r_fall_pend)) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_ncs_rise) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Bit capture, frame commit and error reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed     <= 1'b0;
      r_fall_pend <= 1'b0;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_wr_pulse  <= '0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_pulse  <= '0;
      r_frame_err <= 1'b0;
      if (w_ncs_s) r_armed <= 1'b1;
      if (r_state == ST_DONE && w_ncs_fall) r_fall_pend <= 1'b1;
      else if (r_state == ST_IDLE)          r_fall_pend <= 1'b0;
      if (w_ncs_fall) begin
        r_cnt <= '0;
      end else if (w_bit_rise) begin
        if (r_cnt != CNT_SAT)  r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt < CNT_FULL) r_sr  <= w_sr_nxt;
      end
      if (r_state == ST_DONE) begin
        if (r_cnt == CNT_FULL) begin
          // Out-of-range addresses match no register and are dropped without error.
          if (w_rw == RW_WRITE) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (w_addr == ADDR_W'(i)) begin
                r_regs[i]     <= w_data;
                r_wr_pulse[i] <= 1'b1;
              end
            end
          end
        end else if (r_cnt != '0) begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign bus.regs_out[g*DATA_W +: DATA_W] = r_regs[g];
  end
  assign bus.wr_pulse  = r_wr_pulse;
  assign bus.frame_err = r_frame_err;

`ifdef SPI_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);

  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] w_tx_load;
  logic              r_rd;
  logic              r_dphase;

  // Register selected by the address just completed; unmapped addresses read as zero.
  always_comb begin
    w_tx_load = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_sr_nxt[ADDR_W-1:0] == ADDR_W'(i)) w_tx_load = r_regs[i];
    end
  end

  // Load tx on the last address bit of a read; first fall exposes the MSB, later falls shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx     <= '0;
      r_rd     <= 1'b0;
      r_dphase <= 1'b0;
    end else if (w_ncs_fall) begin
      r_rd     <= 1'b0;
      r_dphase <= 1'b0;
    end else if (r_state == ST_SHIFT && !w_ncs_s) begin
      if (w_sclk_rise && r_cnt == CNT_ADDR) begin
        r_rd <= (w_sr_nxt[ADDR_W] == RW_READ);
        r_tx <= w_tx_load;
      end else if (w_sclk_fall && r_rd) begin
        if (!r_dphase) r_dphase <= 1'b1;
        else           r_tx     <= {r_tx[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign bus.cipo_oe = !w_ncs_s && r_rd && r_dphase;
  assign bus.cipo    = bus.cipo_oe && r_tx[DATA_W-1];
`else
  assign bus.cipo_oe = 1'b0;
  assign bus.cipo    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Randomised self-checking bench for spi_regfile_periph against a frame-level register model.
// Latency: checks commit timing SYNC_STAGES+2 clk after ncs rise and CIPO data per bit.
// Backpressure: controller timing is generated with sclk half periods of HALF clk.
`timescale 1ns/1ps
module tb_spi_regfile_periph;

  localparam int NUM_REGS    = 5;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 6;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  spi_regfile_periph_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) spi_bus ();

  spi_regfile_periph #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(spi_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model_regs [NUM_REGS];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i*8 +: 8] = model_regs[i];
    return v;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clock out bits start_k..nbits-1 of a left-aligned frame and watch CIPO before each rise.
  task automatic drive_bits(input logic [31:0] vec, input int start_k, input int nbits,
                            input logic [7:0] exp_rd, input bit do_chk_rd);
    logic [7:0] rd = '0;
    int oe_bad = 0;
    int cipo_bad = 0;
    bit is_rd = !vec[31];
    for (int k = start_k; k < nbits; k++) begin
      spi_bus.copi = vec[31-k];
      wait_clk(HALF);
      if ((spi_bus.cipo_oe === 1'b1) != (RB && is_rd && k >= 8)) oe_bad++;
      if (!(RB && is_rd && k >= 8 && k < 16) && spi_bus.cipo !== 1'b0) cipo_bad++;
      if (k >= 8 && k < 16) rd = {rd[6:0], spi_bus.cipo};
      spi_bus.sclk = 1'b1;
      wait_clk(HALF);
      spi_bus.sclk = 1'b0;
    end
    chk("cipo_oe_window", oe_bad, 0);
    chk("cipo_idle_zero", cipo_bad, 0);
    if (do_chk_rd) chk("readback_data", rd, exp_rd);
  endtask

  // Observe 10 clk after ncs rise: which write pulse fired, when, and how many frame errors.
  task automatic watch(output logic [4:0] seen_wr, output int wr_cyc, output int wr_n, output int err_n);
    seen_wr = '0; wr_cyc = 0; wr_n = 0; err_n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (spi_bus.wr_pulse != '0) begin
        seen_wr = spi_bus.wr_pulse;
        wr_cyc  = c;
        wr_n++;
      end
      if (spi_bus.frame_err === 1'b1) err_n++;
    end
  endtask

  task automatic run_frame(input logic [31:0] vec, input int nbits, input string tag);
    logic [4:0] exp_wr = '0;
    bit exp_err = 1'b0;
    int a = int'(vec[30:24]);
    logic [7:0] exp_rd;
    logic [4:0] seen_wr;
    int wr_cyc, wr_n, err_n;
    exp_rd = (a < NUM_REGS) ? model_regs[a] : 8'h00;
    if (nbits == 16) begin
      if (vec[31] && a < NUM_REGS) exp_wr[a] = 1'b1;
    end else if (nbits != 0) begin
      exp_err = 1'b1;
    end
    spi_bus.ncs = 1'b0;
    wait_clk(HALF);
    drive_bits(vec, 0, nbits, exp_rd, RB && !vec[31] && nbits >= 16);
    wait_clk(HALF);
    spi_bus.ncs = 1'b1;
    watch(seen_wr, wr_cyc, wr_n, err_n);
    if (exp_wr != '0) model_regs[a] = vec[23:16];
    chk({tag, "_wr_pulse"}, seen_wr, exp_wr);
    chk({tag, "_wr_count"}, wr_n, (exp_wr != '0) ? 1 : 0);
    if (exp_wr != '0) chk({tag, "_wr_latency"}, wr_cyc, SYNC_STAGES + 2);
    chk({tag, "_frame_err"}, err_n, exp_err);
    chk({tag, "_regs_out"}, spi_bus.regs_out, model_vec());
    wait_clk(4);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vec;
    logic [4:0] seen_wr;
    int wr_cyc, wr_n, err_n, len, sel;

    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
    rst = 1'b1;
    spi_bus.ncs  = 1'b1;
    spi_bus.sclk = 1'b0;
    spi_bus.copi = 1'b0;
    wait_clk(3);
    chk("reset_regs_out", spi_bus.regs_out, 64'h0);
    chk("reset_wr_pulse", spi_bus.wr_pulse, 64'h0);
    chk("reset_frame_err", spi_bus.frame_err, 64'h0);
    chk("reset_cipo", spi_bus.cipo, 64'h0);
    chk("reset_cipo_oe", spi_bus.cipo_oe, 64'h0);
    rst = 1'b0;
    wait_clk(6);

    // Directed frames from the test plan.
    run_frame({8'h80, 8'hA5, 16'h0}, 16, "wr_a0");
    run_frame({8'h84, 8'h3C, 16'h0}, 16, "wr_a4");
    run_frame({8'h85, 8'hFF, 16'h0}, 16, "wr_a5_oob");
    run_frame({8'h81, 8'h77, 16'h0}, 12, "short12");
    run_frame({8'h81, 8'h77, 16'h8000}, 17, "long17");
    run_frame({8'h82, 8'h5A, 16'h0}, 16, "wr_a2");
    run_frame({8'h02, 8'h00, 16'h0}, 16, "rd_a2");
    run_frame({8'h06, 8'h00, 16'h0}, 16, "rd_oob");
    run_frame({8'h03, 8'h00, 16'h0}, 12, "rd_short");
    run_frame(32'h0, 0, "empty");

    // Reset in the middle of a write to register 1, ncs held low across release.
    vec = {8'h81, 8'h99, 16'h0};
    spi_bus.ncs = 1'b0;
    wait_clk(HALF);
    drive_bits(vec, 0, 10, 8'h00, 1'b0);
    rst = 1'b1;
    wait_clk(3);
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
    chk("midrst_regs_out", spi_bus.regs_out, model_vec());
    chk("midrst_wr_pulse", spi_bus.wr_pulse, 64'h0);
    chk("midrst_frame_err", spi_bus.frame_err, 64'h0);
    chk("midrst_cipo", spi_bus.cipo, 64'h0);
    chk("midrst_cipo_oe", spi_bus.cipo_oe, 64'h0);
    rst = 1'b0;
    drive_bits(vec, 10, 16, 8'h00, 1'b0);
    wait_clk(HALF);
    spi_bus.ncs = 1'b1;
    watch(seen_wr, wr_cyc, wr_n, err_n);
    chk("postrst_no_write", wr_n, 0);
    chk("postrst_no_err", err_n, 0);
    chk("postrst_regs_out", spi_bus.regs_out, model_vec());
    wait_clk(4);
    run_frame({8'h81, 8'h99, 16'h0}, 16, "wr_a1_after_rst");

    // Randomised frames: mostly full length, some short/long/empty, addresses including unmapped ones.
    for (int n = 0; n < 30; n++) begin
      vec = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom), 16'($urandom)};
      sel = $urandom_range(0, 9);
      if (sel <= 5)      len = 16;
      else if (sel == 6) len = 12;
      else if (sel == 7) len = 17;
      else if (sel == 8) len = 0;
      else               len = $urandom_range(1, 20);
      run_frame(vec, len, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
